player_motion_ctrl: RTL and testbench

Per-frame player motion controller that decodes the USB keycode into a horizontal velocity and runs the jump/gravity state machine. It produces signed per-frame X/Y velocities. It sits directly upstream of the player position/collision stage: that stage adds `vx`/`vy` to the player position each frame and returns ground and ceiling contact flags. All state advances only on `frame_tick`, so motion is frame-rate based regardless of `Clk` frequency.

---
 rtl/player_motion_ctrl.sv | 143 ++++++++++++++
 tb/tb_player_motion_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
// Per-frame player motion controller. Decodes the USB HID keycode into a
// horizontal velocity and runs the ground/rise/fall jump state machine.
// All state advances only on frame_tick, so motion is frame-rate based.

module player_motion_ctrl #(
  parameter int MAX_VX     = 2,
  parameter int JUMP_V     = 10,
  parameter int CUT_V      = 4,
  parameter int TERM_V     = 10,
  parameter int BUF_FRAMES = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic [31:0]        keycode,
  input  logic               on_ground,
  input  logic               head_blocked,
  output logic signed [9:0]  vx,
  output logic signed [9:0]  vy,
  output logic [1:0]         state,
  output logic               facing_left
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } motion_state_t;

  localparam logic signed [9:0] MAX_S  = 10'(MAX_VX);
  localparam logic signed [9:0] JUMP_S = 10'(JUMP_V);
  localparam logic signed [9:0] CUT_S  = 10'(CUT_V);
  localparam logic signed [9:0] TERM_S = 10'(TERM_V);
  localparam logic [7:0]        BUF_L  = 8'(BUF_FRAMES);

  motion_state_t     state_q;
  logic              key_a;
  logic              key_d;
  logic              key_w;
  logic              w_prev;
  logic [7:0]        buf_cnt;
  logic [7:0]        buf_next;
  logic              press;
  logic              jump_req;
  logic signed [9:0] target_vx;
  logic signed [9:0] vy_inc;

  // Any of the four HID key slots may carry A, D or W
  always_comb begin
    key_a = 1'b0;
    key_d = 1'b0;
    key_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == 8'h04) key_a = 1'b1;
      if (keycode[8*i +: 8] == 8'h07) key_d = 1'b1;
      if (keycode[8*i +: 8] == 8'h1A) key_w = 1'b1;
    end
  end

  // Horizontal target speed, jump edge detect and buffer countdown value
  always_comb begin
    target_vx = 10'sd0;
    if (key_a && !key_d)      target_vx = -MAX_S;
    else if (key_d && !key_a) target_vx = MAX_S;
    press    = key_w & ~w_prev;
    jump_req = press | (buf_cnt != 8'd0);
    if (press)                 buf_next = BUF_L;
    else if (buf_cnt != 8'd0)  buf_next = buf_cnt - 8'd1;
    else                       buf_next = 8'd0;
    vy_inc = vy + 10'sd1;
  end

  // Horizontal velocity ramps one pixel per frame toward the target
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vx          <= 10'sd0;
      facing_left <= 1'b0;
    end else if (frame_tick) begin
      if (vx < target_vx)      vx <= vx + 10'sd1;
      else if (vx > target_vx) vx <= vx - 10'sd1;
      if (key_a && !key_d)      facing_left <= 1'b1;
      else if (key_d && !key_a) facing_left <= 1'b0;
    end
  end

  // Jump/gravity state machine with buffered jump requests
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= FALL;
      vy      <= 10'sd0;
      w_prev  <= 1'b0;
      buf_cnt <= 8'd0;
    end else if (frame_tick) begin
      w_prev  <= key_w;
      buf_cnt <= buf_next;
      case (state_q)
        GROUND: begin
          if (jump_req) begin
            state_q <= RISE;
            vy      <= -JUMP_S;
            buf_cnt <= 8'd0;
          end else if (!on_ground) begin
            state_q <= FALL;
            vy      <= 10'sd0;
          end else begin
            vy <= 10'sd0;
          end
        end
        RISE: begin
          if (head_blocked) begin
            state_q <= FALL;
            vy      <= 10'sd0;
          end else if (vy_inc >= 10'sd0) begin
            state_q <= FALL;
            vy      <= 10'sd0;
          end else if (!key_w && (vy < -CUT_S)) begin
            vy <= -CUT_S;
          end else begin
            vy <= vy_inc;
          end
        end
        FALL: begin
          if (on_ground) begin
            state_q <= GROUND;
            vy      <= 10'sd0;
          end else if (vy_inc > TERM_S) begin
            vy <= TERM_S;
          end else begin
            vy <= vy_inc;
          end
        end
        default: begin
          state_q <= FALL;
          vy      <= 10'sd0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb_player_motion_ctrl
// Directed scenarios with literal expectations plus a randomized run
// compared against a frame-level behavioural model of the controller.

module tb_player_motion_ctrl;

  localparam int MAX_VX     = 2;
  localparam int JUMP_V     = 10;
  localparam int CUT_V      = 4;
  localparam int TERM_V     = 10;
  localparam int BUF_FRAMES = 4;

  localparam int S_GROUND = 0;
  localparam int S_RISE   = 1;
  localparam int S_FALL   = 2;

  logic               Clk;
  logic               Reset;
  logic               frame_tick;
  logic [31:0]        keycode;
  logic               on_ground;
  logic               head_blocked;
  logic signed [9:0]  vx;
  logic signed [9:0]  vy;
  logic [1:0]         state;
  logic               facing_left;

  int check_cnt;
  int pass_cnt;

  // Behavioural model state, plain integers
  int m_vx;
  int m_vy;
  int m_state;
  int m_face;
  int m_wprev;
  int m_buf;

  player_motion_ctrl #(
    .MAX_VX(MAX_VX), .JUMP_V(JUMP_V), .CUT_V(CUT_V),
    .TERM_V(TERM_V), .BUF_FRAMES(BUF_FRAMES)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .frame_tick(frame_tick),
    .keycode(keycode),
    .on_ground(on_ground),
    .head_blocked(head_blocked),
    .vx(vx),
    .vy(vy),
    .state(state),
    .facing_left(facing_left)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_vx = 0; m_vy = 0; m_state = S_FALL; m_face = 0; m_wprev = 0; m_buf = 0;
  endtask

  // One frame of the player rules, written at frame level
  task automatic model_step(input logic [31:0] kc, input logic og, input logic hb);
    int a, d, w, tgt, press, jreq, nbuf;
    logic [7:0] b;
    a = 0; d = 0; w = 0;
    for (int i = 0; i < 4; i++) begin
      b = kc[8*i +: 8];
      if (b == 8'h04) a = 1;
      if (b == 8'h07) d = 1;
      if (b == 8'h1A) w = 1;
    end
    tgt = (a == 1 && d == 0) ? -MAX_VX : ((d == 1 && a == 0) ? MAX_VX : 0);
    if (m_vx < tgt) m_vx++;
    else if (m_vx > tgt) m_vx--;
    if (a == 1 && d == 0) m_face = 1;
    else if (d == 1 && a == 0) m_face = 0;
    press = (w == 1 && m_wprev == 0) ? 1 : 0;
    jreq  = (press == 1 || m_buf != 0) ? 1 : 0;
    nbuf  = (press == 1) ? BUF_FRAMES : ((m_buf > 0) ? m_buf - 1 : 0);
    if (m_state == S_GROUND) begin
      if (jreq == 1) begin m_state = S_RISE; m_vy = -JUMP_V; nbuf = 0; end
      else if (!og) begin m_state = S_FALL; m_vy = 0; end
      else m_vy = 0;
    end else if (m_state == S_RISE) begin
      if (hb) begin m_state = S_FALL; m_vy = 0; end
      else if (m_vy + 1 >= 0) begin m_state = S_FALL; m_vy = 0; end
      else if (w == 0 && m_vy < -CUT_V) m_vy = -CUT_V;
      else m_vy = m_vy + 1;
    end else begin
      if (og) begin m_state = S_GROUND; m_vy = 0; end
      else m_vy = (m_vy + 1 > TERM_V) ? TERM_V : m_vy + 1;
    end
    m_buf   = nbuf;
    m_wprev = w;
  endtask

  // Drive inputs and hold frame_tick for n cycles (n frames)
  task automatic do_ticks(input logic [31:0] kc, input logic og, input logic hb, input int n);
    @(negedge Clk);
    keycode      = kc;
    on_ground    = og;
    head_blocked = hb;
    frame_tick   = 1'b1;
    repeat (n) begin
      @(negedge Clk);
      model_step(kc, og, hb);
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; frame_tick = 1'b0; keycode = '0; on_ground = 1'b0; head_blocked = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_cnt++;
    if (vx !== 10'sd0 || vy !== 10'sd0 || state !== 2'b10 || facing_left !== 1'b0)
      $display("[TB] FAIL reset_values: got vx=%0d vy=%0d state=%b face=%b, expected 0 0 10 0",
               vx, vy, state, facing_left);
    else pass_cnt++;
    Reset = 1'b0;
    do_ticks(32'h0, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b00 || vy !== 10'sd0)
      $display("[TB] FAIL first_landing: got state=%b vy=%0d, expected 00 0", state, vy);
    else pass_cnt++;
  endtask

  task automatic test_walk();
    int exp_r[5] = '{1, 2, 2, 1, 0};
    int exp_l[5] = '{-1, -2, -2, -1, 0};
    for (int i = 0; i < 5; i++) begin
      do_ticks((i < 3) ? 32'h00000007 : 32'h00000704, 1'b1, 1'b0, 1);
      check_cnt++;
      if (vx !== 10'(exp_r[i]) || facing_left !== 1'b0)
        $display("[TB] FAIL walk_right step %0d: got vx=%0d face=%b, expected %0d 0",
                 i, vx, facing_left, exp_r[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      do_ticks((i < 3) ? 32'h00000400 : 32'h0, 1'b1, 1'b0, 1);
      check_cnt++;
      if (vx !== 10'(exp_l[i]) || facing_left !== 1'b1)
        $display("[TB] FAIL walk_left step %0d: got vx=%0d face=%b, expected %0d 1",
                 i, vx, facing_left, exp_l[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    do_ticks(32'h00000007, 1'b1, 1'b0, 2);
    check_cnt++;
    if (vx !== 10'sd2 || facing_left !== 1'b0)
      $display("[TB] FAIL back_to_back: got vx=%0d face=%b, expected 2 0", vx, facing_left);
    else pass_cnt++;
    do_ticks(32'h0, 1'b1, 1'b0, 2);
    check_cnt++;
    if (vx !== 10'sd0)
      $display("[TB] FAIL back_to_back_stop: got vx=%0d, expected 0", vx);
    else pass_cnt++;
  endtask

  task automatic test_jump_arc();
    for (int i = 0; i < 10; i++) begin
      do_ticks(32'h0000001A, 1'b0, 1'b0, 1);
      check_cnt++;
      if (state !== 2'b01 || vy !== 10'(i - 10))
        $display("[TB] FAIL jump_rise step %0d: got state=%b vy=%0d, expected 01 %0d",
                 i, state, vy, i - 10);
      else pass_cnt++;
    end
    for (int i = 0; i < 13; i++) begin
      do_ticks(32'h0000001A, 1'b0, 1'b0, 1);
      check_cnt++;
      if (state !== 2'b10 || vy !== 10'((i > 10) ? 10 : i))
        $display("[TB] FAIL jump_fall step %0d: got state=%b vy=%0d, expected 10 %0d",
                 i, state, vy, (i > 10) ? 10 : i);
      else pass_cnt++;
    end
    do_ticks(32'h0, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b00 || vy !== 10'sd0)
      $display("[TB] FAIL jump_land: got state=%b vy=%0d, expected 00 0", state, vy);
    else pass_cnt++;
  endtask

  task automatic test_jump_cut();
    int exp_v[7] = '{-10, -9, -4, -3, -2, -1, 0};
    for (int i = 0; i < 7; i++) begin
      do_ticks((i < 2) ? 32'h1A000000 : 32'h0, 1'b1, 1'b0, 1);
      check_cnt++;
      if (vy !== 10'(exp_v[i]) || state !== ((i < 6) ? 2'b01 : 2'b10))
        $display("[TB] FAIL jump_cut step %0d: got state=%b vy=%0d, expected vy %0d",
                 i, state, vy, exp_v[i]);
      else pass_cnt++;
    end
    do_ticks(32'h0, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b00)
      $display("[TB] FAIL jump_cut_land: got state=%b, expected 00", state);
    else pass_cnt++;
  endtask

  task automatic test_head_bump();
    repeat (4) do_ticks(32'h0000001A, 1'b1, 1'b0, 1);
    check_cnt++;
    if (vy !== -10'sd7 || state !== 2'b01)
      $display("[TB] FAIL head_setup: got state=%b vy=%0d, expected 01 -7", state, vy);
    else pass_cnt++;
    do_ticks(32'h0000001A, 1'b0, 1'b1, 1);
    check_cnt++;
    if (vy !== 10'sd0 || state !== 2'b10)
      $display("[TB] FAIL head_bump: got state=%b vy=%0d, expected 10 0", state, vy);
    else pass_cnt++;
    do_ticks(32'h0, 1'b1, 1'b0, 1);
  endtask

  task automatic test_buffer();
    do_ticks(32'h0, 1'b0, 1'b0, 1);
    do_ticks(32'h001A0000, 1'b0, 1'b0, 1);
    do_ticks(32'h001A0000, 1'b0, 1'b0, 1);
    do_ticks(32'h001A0000, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b00 || vy !== 10'sd0)
      $display("[TB] FAIL buffer_land: got state=%b vy=%0d, expected 00 0", state, vy);
    else pass_cnt++;
    do_ticks(32'h001A0000, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b01 || vy !== -10'sd10)
      $display("[TB] FAIL buffer_jump: got state=%b vy=%0d, expected 01 -10", state, vy);
    else pass_cnt++;
    do_ticks(32'h0, 1'b0, 1'b1, 1);
    do_ticks(32'h0, 1'b1, 1'b0, 1);
    do_ticks(32'h0, 1'b0, 1'b0, 1);
    do_ticks(32'h001A0000, 1'b0, 1'b0, 1);
    repeat (4) do_ticks(32'h001A0000, 1'b0, 1'b0, 1);
    do_ticks(32'h001A0000, 1'b1, 1'b0, 1);
    do_ticks(32'h001A0000, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b00 || vy !== 10'sd0)
      $display("[TB] FAIL buffer_expired: got state=%b vy=%0d, expected 00 0", state, vy);
    else pass_cnt++;
    do_ticks(32'h0, 1'b1, 1'b0, 1);
  endtask

  task automatic test_async_reset();
    repeat (6) do_ticks(32'h0000001A, 1'b1, 1'b0, 1);
    check_cnt++;
    if (vy !== -10'sd5 || state !== 2'b01)
      $display("[TB] FAIL async_setup: got state=%b vy=%0d, expected 01 -5", state, vy);
    else pass_cnt++;
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check_cnt++;
    if (vy !== 10'sd0 || state !== 2'b10 || vx !== 10'sd0)
      $display("[TB] FAIL async_reset: got state=%b vy=%0d vx=%0d, expected 10 0 0", state, vy, vx);
    else pass_cnt++;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    do_ticks(32'h0, 1'b1, 1'b0, 1);
    check_cnt++;
    if (state !== 2'b00 || vy !== 10'sd0)
      $display("[TB] FAIL async_recover: got state=%b vy=%0d, expected 00 0", state, vy);
    else pass_cnt++;
  endtask

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0: return 8'h04;
      1: return 8'h07;
      2: return 8'h1A;
      3, 4: return 8'($urandom_range(0, 255));
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] kc;
    logic og, hb;
    for (int it = 0; it < 300; it++) begin
      for (int i = 0; i < 4; i++) kc[8*i +: 8] = rand_byte();
      og = ($urandom_range(0, 2) == 0);
      hb = ($urandom_range(0, 7) == 0);
      do_ticks(kc, og, hb, ($urandom_range(0, 9) == 0) ? 2 : 1);
      check_cnt++;
      if (vx !== 10'(m_vx) || vy !== 10'(m_vy) || state !== 2'(m_state) || facing_left !== 1'(m_face))
        $display("[TB] FAIL random iter %0d: got vx=%0d vy=%0d state=%0d face=%b, expected %0d %0d %0d %0d",
                 it, vx, vy, state, facing_left, m_vx, m_vy, m_state, m_face);
      else pass_cnt++;
      if (it % 4 == 0) begin
        @(negedge Clk);
        keycode      = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};
        on_ground    = ~on_ground;
        head_blocked = ~head_blocked;
        repeat (2) @(negedge Clk);
        check_cnt++;
        if (vx !== 10'(m_vx) || vy !== 10'(m_vy) || state !== 2'(m_state) || facing_left !== 1'(m_face))
          $display("[TB] FAIL hold_between_ticks iter %0d: got vx=%0d vy=%0d state=%0d, expected %0d %0d %0d",
                   it, vx, vy, state, m_vx, m_vy, m_state);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    check_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_walk();
    test_back_to_back();
    test_jump_arc();
    test_jump_cut();
    test_head_bump();
    test_buffer();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
